// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard and its forwarding-side consumer.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] NO_FWD_REG = 5'd31;

  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_CNT_W    = 2;

  // Operand source select used by the ID-stage forwarding mux.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_EX      = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One tracked register: countdown until its pending write can be forwarded to ID.
module hazard_scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_issue,
  input  logic i_is_load,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] r_cnt;

  // A fresh issue reloads the counter even if an older write is still counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_issue) begin
      r_cnt <= i_is_load ? LOAD_CNT : ALU_CNT;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls ID while a source's producer cannot forward yet.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_valid,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_uses_rs,
  input  logic                  ID_uses_rt,
  input  logic                  ID_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic                  ID_MemRead,
  input  logic                  ID_flush,
  output logic                  stall,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [31:0]           busy_mask
`ifdef HAZARD_STALL_COUNT_EN
  ,
  input  logic                  stall_cnt_clr,
  output logic [15:0]           stall_cycles
`endif
);

  logic        w_issue;
  logic [30:0] w_issue_vec;
  logic [30:0] w_busy;

  // Hazard check uses pre-issue counts only, so an instruction never stalls on itself.
  assign rs_busy = ID_uses_rs && (ID_rs != NO_FWD_REG) && busy_mask[ID_rs];
  assign rt_busy = ID_uses_rt && (ID_rt != NO_FWD_REG) && busy_mask[ID_rt];
  assign stall   = ID_valid && !ID_flush && (rs_busy || rt_busy);

  assign w_issue = ID_valid && !ID_flush && !stall && ID_RegWrite && (ID_rd != NO_FWD_REG);

  generate
    for (genvar gi = 0; gi < 31; gi++) begin : g_entry
      assign w_issue_vec[gi] = w_issue && (ID_rd == REG_ADDR_W'(gi));

      hazard_scoreboard_entry #(
        .CNT_W    (CNT_W),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
      ) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_issue   (w_issue_vec[gi]),
        .i_is_load (ID_MemRead),
        .o_busy    (w_busy[gi])
      );
    end
  endgenerate

  assign busy_mask = {1'b0, w_busy};

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
